instr_dispatcher: RTL and testbench



---
 rtl/maverickOne_pkg.sv | 39 +++
 rtl/exu_credit_counter.sv | 45 ++++
 rtl/instr_dispatcher.sv | 167 ++++++++++++++++
 tb/tb_instr_dispatcher.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/maverickOne_pkg.sv
// Shared types for the maverickOne dispatch stage: decoded instruction layout,
// execution-unit selector and the dispatcher FSM encoding.
package maverickOne_pkg;

  localparam int unsigned NUM_EXU  = 4;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned EXU_W    = $clog2(NUM_EXU);
  localparam int unsigned REG_W    = $clog2(NUM_REGS);

  typedef logic [EXU_W-1:0] exu_sel_t;
  typedef logic [REG_W-1:0] reg_idx_t;

  typedef struct packed {
    logic rd_we;
    logic rs1_re;
    logic rs2_re;
  } reg_req_t;

  typedef struct packed {
    logic [15:0] payload;
    reg_idx_t    rd;
    reg_req_t    reg_req;
    logic        blocking;
    exu_sel_t    exu;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    DRAIN       = 2'd1,
    BLOCK_ISSUE = 2'd2,
    WAIT_BLK    = 2'd3
  } dispatch_state_e;

  // x0 is hard-wired, so writing it never needs a scoreboard lock.
  function automatic logic writes_rd(input decoded_instr_t i);
    return i.reg_req.rd_we && (i.rd != '0);
  endfunction

endpackage

// File: rtl/exu_credit_counter.sv
// Outstanding-instruction credit pool for one execution unit; starts full,
// take_i spends a credit, give_i returns one, clear_i refills and drops give_i.
module exu_credit_counter #(
  parameter int unsigned CREDITS = 2
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic take_i,
  input  logic give_i,
  input  logic clear_i,
  output logic avail_o,
  output logic full_o
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = FULL;
    end else if (take_i && !give_i && count_q != '0) begin
      count_d = count_q - 1'b1;
    end else if (give_i && !take_i && count_q != FULL) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) count_q <= FULL;
    else          count_q <= count_d;
  end

  assign avail_o = (count_q != '0);
  assign full_o  = (count_q == FULL);

  // The count saturates; these flag a protocol bug upstream or downstream.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
    (take_i && !give_i && !clear_i) |-> (count_q != '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!arst_ni)
    (give_i && !take_i && !clear_i) |-> (count_q != FULL));

endmodule

// File: rtl/instr_dispatcher.sv
// Routes launched instructions to NEXU units with per-unit credits and serialises
// blocking instructions. `INSTR_DISPATCHER_PERF_EN adds stall counters.
module instr_dispatcher
  import maverickOne_pkg::*;
#(
  parameter  int unsigned NEXU    = NUM_EXU,
  parameter  int unsigned CREDITS = 2,
  localparam int unsigned NR      = NUM_REGS
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      clear_i,
  input  decoded_instr_t            instr_in_i,
  input  logic                      instr_in_valid_i,
  output logic                      instr_in_ready_o,
  output decoded_instr_t [NEXU-1:0] exu_instr_o,
  output logic [NEXU-1:0]           exu_valid_o,
  input  logic [NEXU-1:0]           exu_ready_i,
  input  logic [NEXU-1:0]           exu_done_i,
  output logic [$clog2(NR)-1:0]     lock_rd_o,
  output logic                      lock_valid_o,
  output logic                      idle_o
`ifdef INSTR_DISPATCHER_PERF_EN
  ,
  output logic [31:0]               stall_credit_o,
  output logic [31:0]               stall_block_o
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and data is held stable while valid & !ready.

  exu_sel_t                  t;
  logic                      t_legal, tgt_ok, all_drained, in_hs;
  logic [NEXU-1:0]           slot_valid_q, slot_valid_d, slot_free, avail, full, take;
  decoded_instr_t [NEXU-1:0] slot_instr_q, slot_instr_d;
  dispatch_state_e           state_q, state_d;
  exu_sel_t                  blk_exu_q, blk_exu_d;
  logic                      idle_q, idle_d;

  assign t = instr_in_i.exu;

  if (NEXU >= (1 << EXU_W)) begin : g_all_legal
    assign t_legal = 1'b1;
  end else begin : g_range_chk
    assign t_legal = (t < EXU_W'(NEXU));
  end

  assign slot_free   = ~slot_valid_q | exu_ready_i;
  assign all_drained = (&full) & ~(|slot_valid_q);
  // Illegal targets are always accepted so they cannot wedge the launcher.
  assign tgt_ok      = t_legal ? (slot_free[t] & avail[t]) : 1'b1;

  always_comb begin
    state_d          = state_q;
    blk_exu_d        = blk_exu_q;
    instr_in_ready_o = 1'b0;
    unique case (state_q)
      RUN: begin
        instr_in_ready_o = tgt_ok & ~instr_in_i.blocking;
        if (instr_in_valid_i && instr_in_i.blocking) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_drained) state_d = BLOCK_ISSUE;
      end
      BLOCK_ISSUE: begin
        instr_in_ready_o = all_drained;
        if (instr_in_valid_i && all_drained) begin
          blk_exu_d = t;
          state_d   = t_legal ? WAIT_BLK : RUN;
        end
      end
      WAIT_BLK: begin
        if (exu_done_i[blk_exu_q]) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (clear_i) begin
      instr_in_ready_o = 1'b0;
      state_d          = RUN;
    end
  end

  assign in_hs = instr_in_valid_i & instr_in_ready_o;

  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    take         = '0;
    for (int u = 0; u < NEXU; u++) begin
      if (slot_valid_q[u] && exu_ready_i[u]) slot_valid_d[u] = 1'b0;
      if (in_hs && t_legal && (t == exu_sel_t'(u))) begin
        take[u]         = 1'b1;
        slot_valid_d[u] = 1'b1;
        slot_instr_d[u] = instr_in_i;
      end
    end
    if (clear_i) slot_valid_d = '0;
  end

  assign idle_d = all_drained & (state_q == RUN);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q      <= RUN;
      blk_exu_q    <= '0;
      slot_valid_q <= '0;
      slot_instr_q <= '0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      blk_exu_q    <= blk_exu_d;
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      idle_q       <= idle_d;
    end
  end

  for (genvar u = 0; u < NEXU; u++) begin : g_credit
    exu_credit_counter #(.CREDITS(CREDITS)) u_credit (
      .clk_i   (clk_i),
      .arst_ni (arst_ni),
      .take_i  (take[u]),
      .give_i  (exu_done_i[u]),
      .clear_i (clear_i),
      .avail_o (avail[u]),
      .full_o  (full[u])
    );
  end

  assign exu_instr_o  = slot_instr_q;
  assign exu_valid_o  = slot_valid_q;
  assign idle_o       = idle_q;
  assign lock_rd_o    = instr_in_i.rd;
  assign lock_valid_o = in_hs & writes_rd(instr_in_i);

  a_legal_target: assert property (@(posedge clk_i) disable iff (!arst_ni)
    in_hs |-> t_legal);

`ifdef INSTR_DISPATCHER_PERF_EN
  logic [31:0] stall_credit_q, stall_credit_d, stall_block_q, stall_block_d;

  always_comb begin
    stall_credit_d = stall_credit_q + 32'(instr_in_valid_i && (state_q == RUN) &&
                     !instr_in_i.blocking && t_legal && !avail[t]);
    stall_block_d  = stall_block_q + 32'((state_q == DRAIN) || (state_q == WAIT_BLK));
    if (clear_i) begin
      stall_credit_d = '0;
      stall_block_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_credit_q <= '0;
      stall_block_q  <= '0;
    end else begin
      stall_credit_q <= stall_credit_d;
      stall_block_q  <= stall_block_d;
    end
  end

  assign stall_credit_o = stall_credit_q;
  assign stall_block_o  = stall_block_q;
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: drivers push expected unit outputs into a
// queue, a negedge monitor pops and compares every unit-side transfer.
module tb_instr_dispatcher;
  import maverickOne_pkg::*;

  localparam int NEXU = NUM_EXU;
  localparam int IW   = $bits(decoded_instr_t);
  localparam int EW   = IW + 8;

  logic                      clk_i = 1'b0;
  logic                      arst_ni = 1'b0;
  logic                      clear_i = 1'b0;
  decoded_instr_t            instr_in_i = '0;
  logic                      instr_in_valid_i = 1'b0;
  logic                      instr_in_ready_o;
  decoded_instr_t [NEXU-1:0] exu_instr_o;
  logic [NEXU-1:0]           exu_valid_o;
  logic [NEXU-1:0]           exu_ready_i = '1;
  logic [NEXU-1:0]           exu_done_i = '0;
  logic [REG_W-1:0]          lock_rd_o;
  logic                      lock_valid_o;
  logic                      idle_o;
`ifdef INSTR_DISPATCHER_PERF_EN
  logic [31:0]               stall_credit_o, stall_block_o;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  instr_dispatcher #(.NEXU(NEXU), .CREDITS(2)) dut (
    .clk_i            (clk_i),
    .arst_ni          (arst_ni),
    .clear_i          (clear_i),
    .instr_in_i       (instr_in_i),
    .instr_in_valid_i (instr_in_valid_i),
    .instr_in_ready_o (instr_in_ready_o),
    .exu_instr_o      (exu_instr_o),
    .exu_valid_o      (exu_valid_o),
    .exu_ready_i      (exu_ready_i),
    .exu_done_i       (exu_done_i),
    .lock_rd_o        (lock_rd_o),
    .lock_valid_o     (lock_valid_o),
    .idle_o           (idle_o)
`ifdef INSTR_DISPATCHER_PERF_EN
    ,
    .stall_credit_o   (stall_credit_o),
    .stall_block_o    (stall_block_o)
`endif
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input int exu, input bit blk, input bit we,
                                        input int rd, input logic [15:0] pl);
    decoded_instr_t i;
    i = '0;
    i.exu           = exu_sel_t'(exu);
    i.blocking      = blk;
    i.reg_req.rd_we = we;
    i.rd            = reg_idx_t'(rd);
    i.payload       = pl;
    return i;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input decoded_instr_t ins);
    instr_in_i       = ins;
    instr_in_valid_i = 1'b1;
  endtask

  task automatic cyc(input string name, input logic exp_rdy);
    logic hs;
    logic exp_lock;
    @(negedge clk_i);
    check({name, "_rdy"}, 64'(instr_in_ready_o), 64'(exp_rdy));
    hs       = instr_in_valid_i && exp_rdy;
    exp_lock = hs && instr_in_i.reg_req.rd_we && (instr_in_i.rd != '0);
    check({name, "_lock"}, 64'(lock_valid_o), 64'(exp_lock));
    if (exp_lock) check({name, "_lockrd"}, 64'(lock_rd_o), 64'(instr_in_i.rd));
    if (hs) exp_q.push_back({8'(instr_in_i.exu), instr_in_i});
    tick();
  endtask

  task automatic pulse_done(input int u);
    exu_done_i    = '0;
    exu_done_i[u] = 1'b1;
    tick();
    exu_done_i = '0;
  endtask

  // Scoreboard monitor: per-unit order is preserved by searching for the oldest entry of that unit
  always @(negedge clk_i) begin
    if (arst_ni) begin
      for (int u = 0; u < NEXU; u++) begin
        if (exu_valid_o[u] && exu_ready_i[u]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][EW-1:IW] == 8'(u)) begin
              idx = i;
              break;
            end
          end
          if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL out_unexpected_u%0d: got %0h expected none", u, exu_instr_o[u]);
          end else begin
            check($sformatf("out_u%0d", u), 64'(exu_instr_o[u]), 64'(exp_q[idx][IW-1:0]));
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    instr_in_i = mk(0, 0, 0, 0, 16'h0000);

    // Reset values, held and after release
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_valid", 64'(exu_valid_o), 64'd0);
    check("rst_instr", 64'(exu_instr_o == '0), 64'd1);
    check("rst_lock", 64'(lock_valid_o), 64'd0);
    tick();
    arst_ni = 1'b1;
    @(negedge clk_i);
    check("t1_idle", 64'(idle_o), 64'd1);
    check("t1_valid", 64'(exu_valid_o), 64'd0);
    tick();
    cyc("t1", 1'b1);

    // Credit exhaustion on unit 1, third waits for a done pulse
    present(mk(1, 0, 0, 0, 16'hA001)); cyc("t2_a", 1'b1);
    present(mk(1, 0, 0, 0, 16'hA002)); cyc("t2_b", 1'b1);
    present(mk(1, 0, 0, 0, 16'hA003));
    cyc("t2_c0", 1'b0);
    cyc("t2_c1", 1'b0);
    cyc("t2_c2", 1'b0);
    exu_done_i = 4'b0010; cyc("t2_cd", 1'b0); exu_done_i = '0;
    cyc("t2_c3", 1'b1);
    instr_in_valid_i = 1'b0;
    pulse_done(1);
    pulse_done(1);

    // Lock strobe on rd writes
    present(mk(0, 0, 1, 5, 16'hD001)); cyc("t3_rd5", 1'b1);
    present(mk(0, 0, 1, 0, 16'hD002)); cyc("t3_rd0", 1'b1);
    present(mk(2, 0, 0, 7, 16'hD003)); cyc("t3_nowe", 1'b1);
    instr_in_valid_i = 1'b0;
    pulse_done(0);
    pulse_done(0);
    pulse_done(2);

    // Blocking instruction drains, issues alone, then gates the next one
    present(mk(2, 0, 0, 0, 16'hB021)); cyc("t4_g1", 1'b1);
    present(mk(2, 0, 0, 0, 16'hB022)); cyc("t4_g2", 1'b1);
    present(mk(0, 1, 1, 9, 16'hB0B0));
    cyc("t4_run", 1'b0);
    cyc("t4_dr0", 1'b0);
    cyc("t4_dr1", 1'b0);
    exu_done_i = 4'b0100; cyc("t4_d1", 1'b0);
    exu_done_i = 4'b0100; cyc("t4_d2", 1'b0);
    exu_done_i = '0;      cyc("t4_d3", 1'b0);
    cyc("t4_blk", 1'b1);
    present(mk(3, 0, 0, 0, 16'hB303));
    cyc("t4_w0", 1'b0);
    cyc("t4_w1", 1'b0);
    exu_done_i = 4'b0001; cyc("t4_wd", 1'b0); exu_done_i = '0;
    cyc("t4_h", 1'b1);
    instr_in_valid_i = 1'b0;
    pulse_done(3);
    tick();
    @(negedge clk_i);
    check("t4_idle", 64'(idle_o), 64'd1);
    tick();

    // Clear with occupied slots and exhausted credits, done pulse in the clear cycle
    present(mk(1, 0, 0, 0, 16'hC011)); cyc("t5_x", 1'b1);
    present(mk(1, 0, 0, 0, 16'hC012)); cyc("t5_y", 1'b1);
    exu_ready_i = '0;
    present(mk(2, 0, 0, 0, 16'hC021)); cyc("t5_z", 1'b1);
    present(mk(0, 0, 1, 3, 16'hC001));
    clear_i = 1'b1; exu_done_i = 4'b0010;
    cyc("t5_clr", 1'b0);
    clear_i = 1'b0; exu_done_i = '0; instr_in_valid_i = 1'b0;
    exp_q.delete();
    @(negedge clk_i);
    check("t5_valid", 64'(exu_valid_o), 64'd0);
    check("t5_rdy", 64'(instr_in_ready_o), 64'd1);
    tick();
    @(negedge clk_i);
    check("t5_idle", 64'(idle_o), 64'd1);
    tick();
    exu_ready_i = '1;
    present(mk(1, 0, 0, 0, 16'hC111)); cyc("t5_cr0", 1'b1);
    present(mk(1, 0, 0, 0, 16'hC112)); cyc("t5_cr1", 1'b1);
    present(mk(1, 0, 0, 0, 16'hC113)); cyc("t5_cr2", 1'b0);
    instr_in_valid_i = 1'b0;
    pulse_done(1);
    pulse_done(1);

`ifdef INSTR_DISPATCHER_PERF_EN
    // Credit stall counter over a 10-cycle stall, then cleared
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    @(negedge clk_i);
    check("t6_zero", 64'(stall_credit_o), 64'd0);
    tick();
    present(mk(1, 0, 0, 0, 16'hE001)); cyc("t6_p1", 1'b1);
    present(mk(1, 0, 0, 0, 16'hE002)); cyc("t6_p2", 1'b1);
    present(mk(1, 0, 0, 0, 16'hE003));
    repeat (10) cyc("t6_stall", 1'b0);
    instr_in_valid_i = 1'b0;
    @(negedge clk_i);
    check("t6_stall_credit", 64'(stall_credit_o), 64'd10);
    check("t6_stall_block", 64'(stall_block_o), 64'd0);
    tick();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    @(negedge clk_i);
    check("t6_cleared", 64'(stall_credit_o), 64'd0);
    tick();
`endif

    // Asynchronous reset in the middle of a cycle
    exu_ready_i = '0;
    present(mk(1, 0, 0, 0, 16'hF001)); cyc("t7_q", 1'b1);
    #2 arst_ni = 1'b0;
    #1;
    check("t7_valid", 64'(exu_valid_o), 64'd0);
    check("t7_idle", 64'(idle_o), 64'd1);
    check("t7_instr", 64'(exu_instr_o == '0), 64'd1);
    instr_in_valid_i = 1'b0;
    exp_q.delete();
    @(posedge clk_i);
    #1 arst_ni = 1'b1;
    exu_ready_i = '1;

    // Drain and final state
    repeat (4) tick();
    check("end_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    check("end_idle", 64'(idle_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
